// File: rtl/arbitor_rr_packet_nreq.sv
// Packet-granular round-robin arbiter for NUM_REQ input streams sharing one output link.
// A grant stays locked from the first flit to the last flit, then priority rotates.
module arbitor_rr_packet_nreq #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req_bus,
  input  logic [NUM_REQ-1:0] i_last_bus,
  input  logic               i_out_ready,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_grant_bus,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_xfer
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     w_grant_idx_nxt;
  logic [NUM_REQ-1:0]   r_grant_bus;
  logic [NUM_REQ-1:0]   w_grant_bus_nxt;

  logic                 w_found;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_cur_req;
  logic                 w_cur_last;
  logic                 w_xfer;
  logic                 w_release;

  // Rotating scan: ptr+1, ptr+2, ... wrapping, so the last-served requester is checked last.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_bus[w_cand]) begin
        w_found   = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_cur_req  = i_req_bus[r_grant_idx];
    w_cur_last = i_last_bus[r_grant_idx];
    w_xfer     = (r_state == StLocked) && w_cur_req && i_out_ready;
    // A withdrawn request aborts the packet even while the output is stalled.
    w_release  = (w_xfer && w_cur_last) || !w_cur_req;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_idx_nxt = r_grant_idx;
    w_grant_bus_nxt = r_grant_bus;
    unique case (r_state)
      StIdle: begin
        if (i_en && w_found) begin
          w_state_nxt     = StLocked;
          w_grant_idx_nxt = w_sel_idx;
          w_grant_bus_nxt = NUM_REQ'(1) << w_sel_idx;
        end
      end
      StLocked: begin
        if (w_release) begin
          w_state_nxt     = StIdle;
          w_ptr_nxt       = r_grant_idx;
          w_grant_idx_nxt = '0;
          w_grant_bus_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_grant_idx <= '0;
      r_grant_bus <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_grant_bus <= w_grant_bus_nxt;
    end
  end

  assign o_valid     = (r_state == StLocked);
  assign o_grant_bus = r_grant_bus;
  assign o_grant_idx = r_grant_idx;
  assign o_xfer      = w_xfer;

endmodule

// File: tb/tb_arbitor_rr_packet_nreq.sv
// Bench for arbitor_rr_packet_nreq: rule-level grant model checked every cycle,
// plus directed scenarios with literal expected grants.
module tb_arbitor_rr_packet_nreq;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic               clk;
  logic               rst_n;
  logic               i_en;
  logic [NUM_REQ-1:0] i_req_bus;
  logic [NUM_REQ-1:0] i_last_bus;
  logic               i_out_ready;
  logic               o_valid;
  logic [NUM_REQ-1:0] o_grant_bus;
  logic [IDX_W-1:0]   o_grant_idx;
  logic               o_xfer;

  int checks = 0;
  int errors = 0;

  arbitor_rr_packet_nreq #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_req_bus  (i_req_bus),
    .i_last_bus (i_last_bus),
    .i_out_ready(i_out_ready),
    .o_valid    (o_valid),
    .o_grant_bus(o_grant_bus),
    .o_grant_idx(o_grant_idx),
    .o_xfer     (o_xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the link and who was served last.
  bit m_valid;
  int m_g;
  int m_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_g     = 0;
      m_ptr   = NUM_REQ - 1;
    end else if (m_valid) begin
      if (!i_req_bus[m_g] || (i_out_ready && i_last_bus[m_g])) begin
        m_valid = 1'b0;
        m_ptr   = m_g;
      end
    end else if (i_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (i_req_bus[c]) begin
          m_valid = 1'b1;
          m_g     = c;
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model valid", 32'(o_valid), 32'(m_valid));
      check("model idx", 32'(o_grant_idx), m_valid ? m_g : 0);
      check("model bus", 32'(o_grant_bus), m_valid ? (1 << m_g) : 0);
      check("model xfer", 32'(o_xfer),
            32'(m_valid && i_req_bus[m_g] && i_out_ready));
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    i_en        = 1'b1;
    i_req_bus   = '0;
    i_last_bus  = '0;
    i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset valid", 32'(o_valid), 0);
    check("reset bus", 32'(o_grant_bus), 0);
    check("reset idx", 32'(o_grant_idx), 0);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where a grant is first visible.
  task automatic wait_grant(input string name, input int idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, " valid"}, 32'(o_valid), 1);
    check({name, " idx"}, 32'(o_grant_idx), idx);
    check({name, " bus"}, 32'(o_grant_bus), 1 << idx);
  endtask

  initial begin
    rst_n = 1'b0;
    // Full request set, single-flit packets: 0,1,2,3,0.
    do_reset();
    i_req_bus  = 4'b1111;
    i_last_bus = 4'b1111;
    wait_grant("rr0", 0);
    @(negedge clk);
    check("rr bubble", 32'(o_valid), 0);
    wait_grant("rr1", 1);
    wait_grant("rr2", 2);
    wait_grant("rr3", 3);
    wait_grant("rr4", 0);

    // Three-flit packet on requester 2 with 0 and 1 also requesting.
    do_reset();
    i_req_bus  = 4'b0010;
    i_last_bus = 4'b1111;
    wait_grant("pk prime", 1);
    #1;
    i_req_bus  = 4'b0111;
    i_last_bus = 4'b1011;
    wait_grant("pk grant", 2);
    step();
    step();
    @(negedge clk);
    check("pk hold", 32'(o_grant_bus), 4'b0100);
    #1 i_last_bus = 4'b1111;
    step();
    wait_grant("pk next", 0);

    // Backpressure on requester 1 for five cycles.
    do_reset();
    i_req_bus  = 4'b0010;
    i_last_bus = 4'b0000;
    wait_grant("bp grant", 1);
    #1 i_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid", 32'(o_valid), 1);
      check("bp xfer", 32'(o_xfer), 0);
      check("bp idx", 32'(o_grant_idx), 1);
    end
    #1;
    i_out_ready = 1'b1;
    i_last_bus  = 4'b0010;
    @(negedge clk);
    check("bp released", 32'(o_valid), 0);
    #1 i_req_bus = 4'b0000;

    // Abort: requester 0 withdraws, pending requester 1 wins after the bubble.
    do_reset();
    i_req_bus  = 4'b0011;
    i_last_bus = 4'b0000;
    wait_grant("ab grant", 0);
    #1 i_req_bus = 4'b0010;
    @(negedge clk);
    check("ab bubble", 32'(o_valid), 0);
    wait_grant("ab next", 1);

    // Enable dropped mid-packet: packet completes, then no new grant.
    do_reset();
    i_req_bus  = 4'b0001;
    i_last_bus = 4'b0000;
    wait_grant("en grant", 0);
    #1 i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en hold", 32'(o_grant_bus), 4'b0001);
    end
    #1 i_last_bus = 4'b1111;
    step();
    i_req_bus = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("en idle", 32'(o_valid), 0);
    end
    #1 i_en = 1'b1;
    wait_grant("en resume", 1);

    // Reset asserted mid-packet with requester 3 granted.
    do_reset();
    i_req_bus  = 4'b1000;
    i_last_bus = 4'b0000;
    wait_grant("rst grant", 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst valid", 32'(o_valid), 0);
    check("rst bus", 32'(o_grant_bus), 0);
    check("rst idx", 32'(o_grant_idx), 0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    i_req_bus  = 4'b1001;
    i_last_bus = 4'b1001;
    wait_grant("rst after", 0);
    wait_grant("rst then", 3);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
